// File: rtl/cpack_length_ctrl.sv
// Length control stage ahead of the compressed-line packer.
// Turns match-code pairs into shift amounts and packer control flags.
module cpack_length_ctrl #(
  parameter int WORD2_LENGTH  = 6,
  parameter int TOTAL_LENGTH  = 7,
  parameter int OUT_SHIFT_BIT = 7,
  parameter int CHUNK_BITS    = 64,
  parameter int LINE_BITS     = 512,
  parameter int COUNT_WIDTH   = 10
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [2:0]               i_code1,
  input  logic [2:0]               i_code2,
  input  logic                     i_last,
  output logic [WORD2_LENGTH-1:0]  o_word2_length,
  output logic [TOTAL_LENGTH-1:0]  o_total_length,
  output logic [OUT_SHIFT_BIT-1:0] o_out_shift,
  output logic                     o_store_flag,
  output logic                     o_push_flag,
  output logic                     o_fill_flag,
  output logic                     o_output_flag,
  output logic                     o_stop_flag,
  output logic [COUNT_WIDTH-1:0]   o_line_bits
);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

  localparam logic [7:0] CHUNK = 8'(CHUNK_BITS);
  localparam logic [COUNT_WIDTH-1:0] LINE_MAX = COUNT_WIDTH'(LINE_BITS);

  state_t state;
  logic [7:0] acc;
  logic [7:0] acc_sum;
  logic accept;
  logic [WORD2_LENGTH-1:0] len1, len2;
  logic [TOTAL_LENGTH-1:0] pair_len;
  logic [OUT_SHIFT_BIT-1:0] shift_nxt;
  logic [COUNT_WIDTH:0] line_sum;
  logic [COUNT_WIDTH-1:0] line_nxt;

  // Reserved codes fall back to the uncompressed length.
  function automatic logic [WORD2_LENGTH-1:0] code_len(
    input logic [2:0] c
  );
    case (c)
      3'b000:  code_len = WORD2_LENGTH'(2);
      3'b001:  code_len = WORD2_LENGTH'(34);
      3'b010:  code_len = WORD2_LENGTH'(6);
      3'b011:  code_len = WORD2_LENGTH'(24);
      3'b100:  code_len = WORD2_LENGTH'(12);
      3'b101:  code_len = WORD2_LENGTH'(16);
      default: code_len = WORD2_LENGTH'(34);
    endcase
  endfunction

  always_comb begin
    accept    = i_valid & o_ready;
    len1      = code_len(i_code1);
    len2      = code_len(i_code2);
    pair_len  = TOTAL_LENGTH'(len1) + TOTAL_LENGTH'(len2);
    acc_sum   = acc + 8'(pair_len);
    shift_nxt = OUT_SHIFT_BIT'(CHUNK - acc);
    line_sum  = {1'b0, o_line_bits}
              + (COUNT_WIDTH+1)'(pair_len);
    line_nxt  = line_sum[COUNT_WIDTH] ? '1
              : line_sum[COUNT_WIDTH-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      acc            <= '0;
      o_ready        <= 1'b1;
      o_word2_length <= '0;
      o_total_length <= '0;
      o_out_shift    <= '0;
      o_store_flag   <= 1'b0;
      o_push_flag    <= 1'b0;
      o_fill_flag    <= 1'b0;
      o_output_flag  <= 1'b0;
      o_stop_flag    <= 1'b0;
      o_line_bits    <= '0;
    end else begin
      o_store_flag  <= 1'b0;
      o_push_flag   <= 1'b0;
      o_fill_flag   <= 1'b0;
      o_output_flag <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            o_word2_length <= len1;
            o_total_length <= pair_len;
            o_line_bits    <= line_nxt;
            if (state == IDLE) o_stop_flag <= 1'b0;
            if (acc_sum >= CHUNK) begin
              o_store_flag <= 1'b1;
              o_out_shift  <= shift_nxt;
              acc          <= acc_sum - CHUNK;
            end else begin
              acc <= acc_sum;
            end
            if (i_last) begin
              state   <= FLUSH;
              o_ready <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        FLUSH: begin
          // Residual bits are padded out to a full chunk.
          if (acc != '0) begin
            o_push_flag  <= 1'b1;
            o_fill_flag  <= 1'b1;
            o_store_flag <= 1'b1;
            o_out_shift  <= shift_nxt;
            acc          <= '0;
          end
          state <= DONE;
        end
        DONE: begin
          o_output_flag <= 1'b1;
          o_stop_flag   <= o_line_bits > LINE_MAX;
          o_line_bits   <= '0;
          acc           <= '0;
          o_ready       <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpack_length_ctrl.sv
// Testbench for cpack_length_ctrl.
// Table vectors, reference length model and expected-result queue.
module tb_cpack_length_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic valid, ready, last;
  logic [2:0] code1, code2;
  logic [5:0] w2_len;
  logic [6:0] tot_len, out_shift;
  logic store, push, fill, outf, stop;
  logic [9:0] line_bits;

  always #5 clk = ~clk;

  cpack_length_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(ready),
    .i_code1(code1), .i_code2(code2), .i_last(last),
    .o_word2_length(w2_len), .o_total_length(tot_len),
    .o_out_shift(out_shift), .o_store_flag(store),
    .o_push_flag(push), .o_fill_flag(fill),
    .o_output_flag(outf), .o_stop_flag(stop),
    .o_line_bits(line_bits)
  );

  typedef struct {
    int w2;
    int tot;
    int st;
    int sh;
    int lb;
  } exp_t;

  typedef struct {
    logic [2:0] c1;
    logic [2:0] c2;
    int w2;
    int tot;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int n_chk = 0;
  int n_pass = 0;
  int m_acc = 0;
  int m_line = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int len(input logic [2:0] c);
    case (c)
      3'b000: return 2;
      3'b010: return 6;
      3'b011: return 24;
      3'b100: return 12;
      3'b101: return 16;
      default: return 34;
    endcase
  endfunction

  task automatic send(input logic [2:0] c1, input logic [2:0] c2,
                      input logic l, input int ew2, input int etot);
    exp_t e;
    int k;
    int s;
    @(negedge clk);
    valid = 1'b1; code1 = c1; code2 = c2; last = l;
    k = 0;
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      chk("ready_timeout", 0, 1);
      valid = 1'b0;
      return;
    end
    s = m_acc + etot;
    e.w2 = ew2;
    e.tot = etot;
    e.st = (s >= 64) ? 1 : 0;
    e.sh = 64 - m_acc;
    m_acc = (s >= 64) ? s - 64 : s;
    m_line = (m_line + etot > 1023) ? 1023 : m_line + etot;
    e.lb = m_line;
    sb.push_back(e);
    @(posedge clk);
    #1;
    valid = 1'b0; last = 1'b0;
    e = sb.pop_front();
    chk("word2_length", int'(w2_len), e.w2);
    chk("total_length", int'(tot_len), e.tot);
    chk("store_flag", int'(store), e.st);
    if (e.st == 1) chk("out_shift", int'(out_shift), e.sh);
    chk("line_bits", int'(line_bits), e.lb);
    chk("push_idle", int'(push), 0);
  endtask

  task automatic send_auto(input logic [2:0] c1, input logic [2:0] c2,
                           input logic l);
    send(c1, c2, l, len(c1), len(c1) + len(c2));
  endtask

  // Called right after the last accept; walks FLUSH and DONE.
  task automatic finish_line();
    int f;
    int es;
    chk("ready_flush", int'(ready), 0);
    f = (m_acc != 0) ? 1 : 0;
    es = (m_line > 512) ? 1 : 0;
    @(posedge clk);
    #1;
    chk("push_flag", int'(push), f);
    chk("fill_flag", int'(fill), f);
    chk("flush_store", int'(store), f);
    if (f == 1) chk("flush_shift", int'(out_shift), 64 - m_acc);
    chk("output_early", int'(outf), 0);
    chk("ready_done", int'(ready), 0);
    chk("line_bits_flush", int'(line_bits), m_line);
    m_acc = 0;
    @(posedge clk);
    #1;
    chk("output_flag", int'(outf), 1);
    chk("stop_flag", int'(stop), es);
    chk("store_done", int'(store), 0);
    chk("line_cleared", int'(line_bits), 0);
    chk("ready_idle", int'(ready), 1);
    m_line = 0;
  endtask

  task automatic check_reset_state();
    chk("rst_ready", int'(ready), 1);
    chk("rst_w2", int'(w2_len), 0);
    chk("rst_tot", int'(tot_len), 0);
    chk("rst_shift", int'(out_shift), 0);
    chk("rst_flags", int'({store, push, fill, outf, stop}), 0);
    chk("rst_line", int'(line_bits), 0);
  endtask

  initial begin
    tbl[0] = '{3'b000, 3'b000, 2, 4};
    tbl[1] = '{3'b001, 3'b001, 34, 68};
    tbl[2] = '{3'b010, 3'b011, 6, 30};
    tbl[3] = '{3'b111, 3'b000, 34, 36};
    tbl[4] = '{3'b100, 3'b101, 12, 28};
    tbl[5] = '{3'b110, 3'b010, 34, 40};
    tbl[6] = '{3'b011, 3'b100, 24, 36};
    tbl[7] = '{3'b101, 3'b001, 16, 50};

    rst = 1'b1; valid = 1'b0; last = 1'b0;
    code1 = '0; code2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;

    // 8 x 000/000: 32 bits, no store until the flush
    for (int i = 0; i < 8; i++) send_auto(3'b000, 3'b000, i == 7);
    finish_line();
    @(posedge clk);
    #1;
    chk("output_pulse", int'(outf), 0);
    chk("stop_hold", int'(stop), 0);

    // Mixed code table, one line
    for (int i = 0; i < 8; i++)
      send(tbl[i].c1, tbl[i].c2, i == 7, tbl[i].w2, tbl[i].tot);
    finish_line();

    // 8 x 001/001: store every pair, stop at 544 bits
    for (int i = 0; i < 8; i++) send_auto(3'b001, 3'b001, i == 7);
    // Pair offered during FLUSH/DONE must wait for IDLE
    valid = 1'b1; code1 = 3'b010; code2 = 3'b010; last = 1'b0;
    finish_line();
    chk("stop_before_accept", int'(stop), 1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk("held_w2", int'(w2_len), 6);
    chk("held_tot", int'(tot_len), 12);
    chk("held_line", int'(line_bits), 12);
    chk("stop_clear", int'(stop), 0);
    chk("held_out", int'(outf), 0);
    m_acc = 12;
    m_line = 12;

    // Reset after 3 pairs of a line
    send_auto(3'b001, 3'b011, 1'b0);
    send_auto(3'b101, 3'b100, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;
    m_acc = 0;
    m_line = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("no_output_after_rst", int'(outf), 0);
    end

    // Fresh line after reset: acc must start from zero
    for (int i = 0; i < 8; i++) send_auto(3'b000, 3'b000, i == 7);
    finish_line();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
